// File: rtl/dm_cache_ctrl.sv
// ============================================================================
//  Module   : dm_cache_ctrl
//  Brief    : Direct-mapped write-back/write-allocate data cache (4 x 16-bit
//             words per line) with its miss-handling controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dm_cache_ctrl #(
    parameter int LINES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 13 - IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q;
    logic [15:0]      req_addr_q;
    logic [15:0]      req_data_q;
    logic             req_wr_q;
    logic [15:0]      dout_q;

    logic [TAG_W-1:0] tag_q   [LINES];
    logic [15:0]      data_q  [LINES][4];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    // Outside IDLE the lookup follows the latched request, not the live bus.
    logic [15:0]      w_addr;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [1:0]       w_off;
    logic             w_hit, w_req, w_illegal, w_accept;
    logic             w_hit_done, w_miss, w_wr_hit, w_last;
    logic             w_wb_ack, w_fill_ack;
    logic [15:0]      w_word;

    assign w_addr     = (state_q == S_IDLE) ? Addr : req_addr_q;
    assign w_idx      = w_addr[IDX_W+2:3];
    assign w_tag      = w_addr[15:IDX_W+3];
    assign w_off      = w_addr[2:1];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_req      = Rd | Wr;
    assign w_illegal  = (Rd & Wr) | (w_req & Addr[0]);
    assign w_accept   = (state_q == S_IDLE) && w_req && !w_illegal;
    assign w_hit_done = w_accept & w_hit;
    assign w_miss     = w_accept & ~w_hit;
    assign w_wr_hit   = w_hit_done & Wr;
    assign w_last     = (cnt_q == 2'd3);
    assign w_wb_ack   = (state_q == S_WB) & mem_ack;
    assign w_fill_ack = (state_q == S_FILL) & mem_ack;
    assign w_word     = data_q[w_idx][w_off];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_miss) begin
                    state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB : S_FILL;
                end
            end
            S_WB:    if (w_wb_ack && w_last) state_d = S_FILL;
            S_FILL:  if (w_fill_ack && w_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request-side outputs are forced low while reset is held.
    always_comb begin
        Done      = 1'b0;
        CacheHit  = 1'b0;
        Stall     = 1'b0;
        Err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    Done     = w_hit_done;
                    CacheHit = w_hit_done;
                    Stall    = w_miss;
                    Err      = w_req & w_illegal;
                end
                S_WB: begin
                    Stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {tag_q[w_idx], w_idx, cnt_q, 1'b0};
                    mem_wdata = data_q[w_idx][cnt_q];
                end
                S_FILL: begin
                    Stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {w_tag, w_idx, cnt_q, 1'b0};
                end
                default: Done = 1'b1;
            endcase
        end
    end

    assign DataOut = Done ? w_word : dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            req_addr_q <= 16'h0000;
            req_data_q <= 16'h0000;
            req_wr_q   <= 1'b0;
            dout_q     <= 16'h0000;
        end else begin
            if (w_wb_ack || w_fill_ack) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (w_miss) begin
                req_addr_q <= Addr;
                req_data_q <= DataIn;
                req_wr_q   <= Wr;
            end
            if (Done) begin
                dout_q <= DataOut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (w_wr_hit) begin
                dirty_q[w_idx] <= 1'b1;
            end
            if (w_fill_ack && w_last) begin
                valid_q[w_idx] <= 1'b1;
                dirty_q[w_idx] <= 1'b0;
            end
            if (state_q == S_DONE && req_wr_q) begin
                dirty_q[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            data_q[w_idx][w_off] <= DataIn;
        end
        if (w_fill_ack) begin
            data_q[w_idx][cnt_q] <= mem_rdata;
            if (w_last) begin
                tag_q[w_idx] <= w_tag;
            end
        end
        if (state_q == S_DONE && req_wr_q) begin
            data_q[w_idx][w_off] <= req_data_q;
        end
    end

endmodule

`default_nettype wire

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with its controller FSM.
- Sits between the pipeline's memory stage and the backing word memory.
- Returns load data and completion to the memory stage, and produces the CacheHit/request indications that the simulation monitor counts.
- Lines hold 4 x 16-bit words; tag, data, valid and dirty arrays are internal.

Parameters:
- LINES, 32: number of cache lines. Power of 2, range 2..128.
- IDX_W, log2(LINES): index width, derived. Tag width = 13 - IDX_W.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- Rd, input, 1: load request.
- Wr, input, 1: store request.
- Addr, input, 16: byte address. Bit 0 must be 0. [2:1] word offset, [IDX_W+2:3] index, [15:IDX_W+3] tag.
- DataIn, input, 16: store data.
- DataOut, output, 16: load data, valid while Done=1.
- Done, output, 1: one-cycle completion pulse.
- Stall, output, 1: request accepted, not yet complete.
- CacheHit, output, 1: completion was a hit. Only ever high together with Done.
- Err, output, 1: illegal request, one-cycle pulse.
- mem_req, output, 1: backing-memory word request.
- mem_we, output, 1: 1 = write, 0 = read.
- mem_addr, output, 16: word-aligned byte address.
- mem_wdata, output, 16: write data.
- mem_ack, input, 1: memory completes the current word.
- mem_rdata, input, 16: read data, valid in the mem_ack cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All valid and dirty bits cleared; FSM to IDLE; word counter = 0.
  - Done, Stall, CacheHit, Err, mem_req, mem_we = 0; DataOut, mem_addr, mem_wdata = 0.
  - Reset mid-writeback or mid-fill abandons the transaction. mem_req drops immediately; memory contents are not guaranteed consistent.
- Request rules:
  - Requests are sampled only in IDLE; Rd, Wr and Addr are ignored in all other states.
  - The requester holds Rd, Wr, Addr and DataIn stable until Done.
- Err:
  - Condition: Rd&Wr, or (Rd|Wr)&Addr[0]=1.
  - Response: Err=1 for that cycle only; no array or FSM change; Done=0.
- Hit (IDLE, legal request, valid & tag match):
  - Done=1 and CacheHit=1 in the same cycle. Zero-cycle latency, combinational lookup of registered arrays.
  - Load: DataOut = selected word.
  - Store: word written at the clock edge; dirty set.
- Miss (IDLE): Stall=1 in that cycle. The controller latches Addr, DataIn and the op.
  - Line valid & dirty -> WRITEBACK.
  - Otherwise -> FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={old tag, index, cnt, 1'b0}, mem_wdata = line word cnt.
  - On mem_ack: cnt+1. When cnt=3 is acked, cnt=0 and FSM -> FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={new tag, index, cnt, 1'b0}.
  - On mem_ack: mem_rdata is written to word cnt; cnt+1.
  - Ack of cnt=3: tag updated, valid=1, dirty=0; FSM -> DONE.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable until mem_ack is sampled.
  - mem_req is high continuously through the whole transaction; no idle cycle between words.
  - mem_ack with mem_req=0 is ignored.
- DONE (one cycle):
  - Done=1, CacheHit=0, Stall=0.
  - Load: DataOut = filled word.
  - Store: latched DataIn is written to the word at the edge; dirty=1.
  - FSM -> IDLE. A new request is accepted the cycle after DONE.
- Stall:
  - 1 in the IDLE miss cycle, in WRITEBACK and in FILL.
  - 0 in DONE and on hits.
- Misc:
  - DataOut holds its last value when Done=0.
  - Minimum miss latency: 1 + 4 cycles (clean) or 1 + 8 cycles (dirty) at zero-wait memory, plus the DONE cycle.
  - cnt wraps 3 -> 0.

Test Plan:
1. Reset, load 0x0010, memory returns 0xA0..0xA3 with ack each cycle -> reads at 0x0010/12/14/16, then Done with DataOut=0x00A0 and CacheHit=0. Next load 0x0014 -> same-cycle Done, CacheHit=1, DataOut=0x00A2, no mem_req.
2. Store 0x1234 to 0x0010 (hit), then load 0x0110 (same index, LINES=32) -> writeback of 0x1234, 0xA1, 0xA2, 0xA3 to 0x0010..16, fill from 0x0110..16, Done.
3. Store miss 0x0200 with DataIn=0xBEEF -> fill, Done. Load 0x0200 -> hit, 0xBEEF. Evicting 0x0200 writes back 0xBEEF.
4. Load 0x0011, then Rd=Wr=1 at 0x0020 -> Err=1 for one cycle each; no mem_req, no Done. A subsequent load 0x0020 misses.
5. mem_ack delayed 3 cycles per word -> mem_addr and mem_req stable while waiting; Stall stays 1; Done exactly once.
6. rst_n low during the second fill word -> all outputs 0 immediately. Re-load of the same address -> miss (valid cleared).
